// File: rtl/sqrt2_pkg.sv
// rtl/sqrt2_pkg.sv - shared types and constants for the sqrt2 host initiator
package sqrt2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } host_state_t;

  localparam logic [15:0] FP16_QNAN = 16'h7E00;

  typedef struct packed {
    logic [15:0] data;
    logic        nan;
    logic        pinf;
    logic        ninf;
    logic        timeout;
  } sqrt2_rsp_t;

endpackage

// File: rtl/sqrt2_bus_pad.sv
// rtl/sqrt2_bus_pad.sv - 16-bit tri-state pad for the shared IO_DATA bus
module sqrt2_bus_pad (
  input  logic        oe,
  input  logic [15:0] dout,
  output logic [15:0] din,
  inout  wire  [15:0] pad
);

  assign pad = oe ? dout : 16'bz;
  assign din = pad;

endmodule

// File: rtl/sqrt2_host.sv
// rtl/sqrt2_host.sv - host initiator: drives an FP16 operand to the sqrt2 engine
// and returns the engine result (or a timeout NaN) on a valid/ready port.
module sqrt2_host
  import sqrt2_pkg::*;
#(
  parameter int          TIMEOUT = 15,
  parameter logic [15:0] QNAN    = FP16_QNAN
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_nan,
  output logic        rsp_pinf,
  output logic        rsp_ninf,
  output logic        rsp_timeout,
  inout  wire  [15:0] IO_DATA,
  output logic        ENABLE,
  input  logic        RESULT,
  input  logic        IS_NAN,
  input  logic        IS_PINF,
  input  logic        IS_NINF
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  host_state_t state_q, state_d;
  logic [15:0] opnd_q, opnd_d;
  logic [7:0]  cnt_q, cnt_d;
  sqrt2_rsp_t  rsp_q, rsp_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        enable_q, enable_d;
  logic [15:0] bus_din;
  logic        bus_oe;

  // Host owns the bus only during the single DRIVE cycle.
  assign bus_oe = (state_q == DRIVE);

  sqrt2_bus_pad u_pad (
    .oe   (bus_oe),
    .dout (opnd_q),
    .din  (bus_din),
    .pad  (IO_DATA)
  );

  always_comb begin
    state_d     = state_q;
    opnd_d      = opnd_q;
    cnt_d       = cnt_q;
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q;
    enable_d    = enable_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          opnd_d   = req_data;
          enable_d = 1'b1;
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        cnt_d   = 8'd0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (RESULT) begin
          rsp_d       = '{data: bus_din, nan: IS_NAN, pinf: IS_PINF, ninf: IS_NINF, timeout: 1'b0};
          rsp_valid_d = 1'b1;
          enable_d    = 1'b0;
          state_d     = DONE;
        end else if (cnt_q == CNT_LAST) begin
          rsp_d       = '{data: QNAN, nan: 1'b0, pinf: 1'b0, ninf: 1'b0, timeout: 1'b1};
          rsp_valid_d = 1'b1;
          enable_d    = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      opnd_q      <= '0;
      cnt_q       <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      enable_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      opnd_q      <= opnd_d;
      cnt_q       <= cnt_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      enable_q    <= enable_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_q.data;
  assign rsp_nan     = rsp_q.nan;
  assign rsp_pinf    = rsp_q.pinf;
  assign rsp_ninf    = rsp_q.ninf;
  assign rsp_timeout = rsp_q.timeout;
  assign ENABLE      = enable_q;

endmodule
